// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage load/store unit. Turns a load or store held in the
//                EX/MEM register into a req/ack data-memory transaction,
//                stalls the upstream pipeline until it completes, and
//                registers the aligned, extended load result for MEM/WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [3:0]  ld_op_i,
    input  logic        is_load_i,
    input  logic        mem_wren_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] ld_data_o,
    output logic        ld_valid_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value on the last BUSY cycle allowed before the access is aborted
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        ld_data_q;
    logic               ld_valid_q;
    logic               misalign_q;
    logic               timeout_q;

    logic               w_memop;
    logic               w_busy;
    logic [1:0]         w_offset;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_is_unsigned;
    logic               w_misalign;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shifted;
    logic [31:0]        w_ld_ext;

    // Access size decode; any code that is not a byte or half is a word
    assign w_memop       = is_load_i | mem_wren_i;
    assign w_busy        = (state_q == BUSY);
    assign w_offset      = alu_data_i[1:0];
    assign w_is_byte     = (ld_op_i == 4'b0000) || (ld_op_i == 4'b0100);
    assign w_is_half     = (ld_op_i == 4'b0001) || (ld_op_i == 4'b0101);
    assign w_is_unsigned = ld_op_i[2];
    assign w_misalign    = (w_is_half & w_offset[0]) |
                           (~w_is_byte & ~w_is_half & (w_offset != 2'b00));

    // Byte-enable and replicated write-data generation from size and offset
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_i;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_offset;
            w_wdata = {4{rs2_data_i[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << w_offset;
            w_wdata = {2{rs2_data_i[15:0]}};
        end
    end

    // Load alignment: bring the addressed lane to bit 0, then extend
    always_comb begin
        w_shifted = dmem_rdata_i >> {w_offset, 3'b000};
        w_ld_ext  = w_shifted;
        if (w_is_byte) begin
            w_ld_ext = w_is_unsigned ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            w_ld_ext = w_is_unsigned ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    // Access FSM with its registered result and one-cycle status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_memop) begin
                        if (w_misalign) begin
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                            if (is_load_i) begin
                                ld_data_q <= '0;
                            end
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack_i) begin
                        state_q <= DONE;
                        if (is_load_i) begin
                            ld_data_q  <= w_ld_ext;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_q   <= DONE;
                        timeout_q <= 1'b1;
                        if (is_load_i) begin
                            ld_data_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The EX/MEM register is frozen while stalled, so address, data and
    // enables stay stable for the whole request without extra capture flops
    assign dmem_req_o   = w_busy;
    assign dmem_we_o    = w_busy & mem_wren_i & ~is_load_i;
    assign dmem_addr_o  = {alu_data_i[31:2], 2'b00};
    assign dmem_wdata_o = w_wdata;
    assign dmem_be_o    = w_busy ? w_be : 4'b0000;
    assign stall_o      = ((state_q == IDLE) & w_memop) | w_busy;

    assign ld_data_o    = ld_data_q;
    assign ld_valid_o   = ld_valid_q;
    assign misalign_o   = misalign_q;
    assign timeout_o    = timeout_q;

endmodule
`default_nettype wire
